// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types for the HUB75 column shifters.
//   state_t : column shifter sequencing states
//     IDLE  waiting for ctrl_go
//     F0    first RAM read issued (column 0)
//     F1    first RAM word on ram_data
//     LOW   phy_clk low phase of a column
//     HIGH  phy_clk high phase of a column
package hub75_pkg;
    typedef enum logic [2:0] {
        IDLE,
        F0,
        F1,
        LOW,
        HIGH
    } state_t;
endpackage

// File: rtl/hub75_plane_mux.sv
// hub75_plane_mux: picks one bit plane out of every bank/channel field of a
// RAM word. Field i occupies ram_data[i*N_PLANES +: N_PLANES].
//   ram_data : packed RAM word, N_LANES fields of N_PLANES bits
//   plane    : plane index (binary)
//   bits     : one bit per bank/channel lane
module hub75_plane_mux #(
    parameter int N_LANES      = 6,
    parameter int N_PLANES     = 8,
    parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
    input  logic [N_LANES*N_PLANES-1:0] ram_data,
    input  logic [LOG_N_PLANES-1:0]     plane,
    output logic [N_LANES-1:0]          bits
);
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [N_PLANES-1:0] field;
        assign field   = ram_data[i*N_PLANES +: N_PLANES];
        assign bits[i] = field[plane];
    end
endmodule

// File: rtl/hub75_shift_div.sv
// hub75_shift_div: HUB75 column shifter with a runtime shift-clock divider.
// One RAM word is read per column; one bit plane per bank/channel is driven
// on phy_data while phy_clk runs a low phase then a high phase, each
// ctrl_div+1 cycles long. The next column is prefetched on the last LOW
// cycle so phy_data only changes on the HIGH->LOW boundary.
//   clk, rst      : clock, asynchronous active-high reset
//   phy_data      : registered column data, one bit per bank/channel
//   phy_clk       : registered panel shift clock
//   ram_data      : RAM word, valid the cycle after ram_rden
//   ram_col_addr  : RAM column address (holds when ram_rden is low)
//   ram_rden      : RAM read enable
//   ctrl_plane    : bit plane to shift
//   ctrl_ncols    : column count minus one
//   ctrl_div      : phase length minus one
//   ctrl_go       : start request, taken only while ctrl_rdy
//   ctrl_abort    : drop the current line, no ctrl_done
//   ctrl_rdy      : idle
//   ctrl_done     : one-cycle pulse after the last column
module hub75_shift_div
    import hub75_pkg::*;
#(
    parameter int N_BANKS      = 2,
    parameter int N_COLS       = 64,
    parameter int N_CHANS      = 3,
    parameter int N_PLANES     = 8,
    parameter int DIV_W        = 4,
    parameter int LOG_N_COLS   = $clog2(N_COLS),
    parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [N_BANKS*N_CHANS-1:0]           phy_data,
    output logic                                 phy_clk,
    input  logic [N_BANKS*N_CHANS*N_PLANES-1:0]  ram_data,
    output logic [LOG_N_COLS-1:0]                ram_col_addr,
    output logic                                 ram_rden,
    input  logic [LOG_N_PLANES-1:0]              ctrl_plane,
    input  logic [LOG_N_COLS-1:0]                ctrl_ncols,
    input  logic [DIV_W-1:0]                     ctrl_div,
    input  logic                                 ctrl_go,
    input  logic                                 ctrl_abort,
    output logic                                 ctrl_rdy,
    output logic                                 ctrl_done
);
    localparam int N_LANES = N_BANKS * N_CHANS;

    state_t                  state, state_nx;
    logic [LOG_N_PLANES-1:0] plane_q;
    logic [LOG_N_COLS-1:0]   ncols_q, col_q, addr_q;
    logic [DIV_W-1:0]        div_q, ph_q;
    logic [N_LANES-1:0]      shadow, mux_bits, next_data;
    logic                    rden_q, phase_end, last_col, abort_act;

    hub75_plane_mux #(
        .N_LANES     (N_LANES),
        .N_PLANES    (N_PLANES),
        .LOG_N_PLANES(LOG_N_PLANES)
    ) u_mux (
        .ram_data(ram_data),
        .plane   (plane_q),
        .bits    (mux_bits)
    );

    assign phase_end = (ph_q == div_q);
    assign last_col  = (col_q == ncols_q);
    assign abort_act = ctrl_abort && (state != IDLE);
    assign ctrl_rdy  = (state == IDLE);
    // With div=0 the prefetched word arrives in the same cycle it must be
    // loaded, so bypass the shadow while the read is still on ram_data.
    assign next_data = rden_q ? mux_bits : shadow;

    always_comb begin
        state_nx     = state;
        ram_rden     = 1'b0;
        ram_col_addr = addr_q;
        case (state)
            IDLE: if (ctrl_go) state_nx = F0;
            F0: begin
                ram_rden     = 1'b1;
                ram_col_addr = '0;
                state_nx     = F1;
            end
            F1: state_nx = LOW;
            LOW: if (phase_end) begin
                state_nx = HIGH;
                if (!last_col) begin
                    ram_rden     = 1'b1;
                    ram_col_addr = col_q + 1'b1;
                end
            end
            HIGH: if (phase_end) state_nx = last_col ? IDLE : LOW;
            default: state_nx = IDLE;
        endcase
        if (abort_act) begin
            state_nx     = IDLE;
            ram_rden     = 1'b0;
            ram_col_addr = addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phy_data  <= '0;
            phy_clk   <= 1'b0;
            ctrl_done <= 1'b0;
            addr_q    <= '0;
            rden_q    <= 1'b0;
            shadow    <= '0;
            plane_q   <= '0;
            ncols_q   <= '0;
            div_q     <= '0;
            col_q     <= '0;
            ph_q      <= '0;
        end else begin
            state     <= state_nx;
            addr_q    <= ram_col_addr;
            rden_q    <= ram_rden;
            ctrl_done <= 1'b0;
            if (rden_q) shadow <= mux_bits;
            if (abort_act) begin
                phy_clk  <= 1'b0;
                phy_data <= '0;
            end else begin
                case (state)
                    IDLE: if (ctrl_go) begin
                        plane_q <= ctrl_plane;
                        ncols_q <= ctrl_ncols;
                        div_q   <= ctrl_div;
                        col_q   <= '0;
                        ph_q    <= '0;
                    end
                    F1: phy_data <= next_data;
                    LOW: begin
                        if (phase_end) begin
                            ph_q    <= '0;
                            phy_clk <= 1'b1;
                        end else begin
                            ph_q <= ph_q + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (phase_end) begin
                            ph_q    <= '0;
                            phy_clk <= 1'b0;
                            if (last_col) begin
                                phy_data  <= '0;
                                ctrl_done <= 1'b1;
                            end else begin
                                phy_data <= next_data;
                                col_q    <= col_q + 1'b1;
                            end
                        end else begin
                            ph_q <= ph_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hub75_shift_div.sv
module tb_hub75_shift_div;
    localparam int NL = 6;
    localparam int NP = 8;
    localparam int W  = NL * NP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] phy_data;
    logic          phy_clk;
    logic [W-1:0]  ram_data = '0;
    logic [5:0]    ram_col_addr;
    logic          ram_rden;
    logic [2:0]    ctrl_plane = '0;
    logic [5:0]    ctrl_ncols = '0;
    logic [3:0]    ctrl_div = '0;
    logic          ctrl_go = 1'b0;
    logic          ctrl_abort = 1'b0;
    logic          ctrl_rdy;
    logic          ctrl_done;

    logic [W-1:0]  mem [64];
    int            errors = 0;
    int            checks = 0;

    hub75_shift_div dut (
        .clk(clk), .rst(rst), .phy_data(phy_data), .phy_clk(phy_clk),
        .ram_data(ram_data), .ram_col_addr(ram_col_addr), .ram_rden(ram_rden),
        .ctrl_plane(ctrl_plane), .ctrl_ncols(ctrl_ncols), .ctrl_div(ctrl_div),
        .ctrl_go(ctrl_go), .ctrl_abort(ctrl_abort), .ctrl_rdy(ctrl_rdy),
        .ctrl_done(ctrl_done)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency
    always_ff @(posedge clk) if (ram_rden) ram_data <= mem[ram_col_addr];

    function automatic logic [NL-1:0] exp_bits(int c, int p);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = mem[c][i*NP + p];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " clk"}, 64'(phy_clk), 64'd0);
        chk({tag, " data"}, 64'(phy_data), 64'd0);
        chk({tag, " rden"}, 64'(ram_rden), 64'd0);
        chk({tag, " rdy"}, 64'(ctrl_rdy), 64'd1);
        chk({tag, " done"}, 64'(ctrl_done), 64'd0);
    endtask

    // Runs one line and checks every cycle against a timing model; column
    // data is also scoreboarded: pushed at go, popped on each phy_clk rise.
    task automatic run_line(input int p, input int n, input int d,
                            input int abort_col, input bit disturb);
        int P, T, ka, kend, col, ph;
        bit in_line, ab, e_clk, e_rden, e_rdy, e_done;
        logic [NL-1:0] e_data;
        logic prev_clk;
        logic [NL-1:0] q[$];
        string tg;
        P  = 2 * (d + 1);
        T  = 3 + (n + 1) * P;
        ka = (abort_col >= 0) ? 3 + abort_col * P + d + 1 : T + 100;
        kend = (abort_col >= 0) ? ka + 3 : T + 2;
        q.delete();
        for (int c = 0; c <= n; c++) q.push_back(exp_bits(c, p));
        @(negedge clk);
        ctrl_plane = 3'(p); ctrl_ncols = 6'(n); ctrl_div = 4'(d); ctrl_go = 1'b1;
        @(posedge clk);
        #1 ctrl_go = 1'b0;
        prev_clk = 1'b0;
        for (int k = 1; k <= kend; k++) begin
            @(negedge clk);
            tg = $sformatf("p%0d n%0d d%0d k%0d", p, n, d, k);
            ab = (k > ka);
            in_line = !ab && k >= 3 && k < T;
            col = in_line ? (k - 3) / P : 0;
            ph  = in_line ? (k - 3) % P : 0;
            e_clk  = in_line && ph >= d + 1;
            e_rden = !ab && (k == 1 || (in_line && ph == d && col < n));
            e_rdy  = ab || k >= T;
            e_done = !ab && k == T;
            e_data = in_line ? exp_bits(col, p) : '0;
            chk({tg, " clk"}, 64'(phy_clk), 64'(e_clk));
            chk({tg, " rden"}, 64'(ram_rden), 64'(e_rden));
            if (e_rden) chk({tg, " addr"}, 64'(ram_col_addr), (k == 1) ? 64'd0 : 64'(col + 1));
            chk({tg, " rdy"}, 64'(ctrl_rdy), 64'(e_rdy));
            chk({tg, " done"}, 64'(ctrl_done), 64'(e_done));
            chk({tg, " data"}, 64'(phy_data), 64'(e_data));
            if (phy_clk && !prev_clk) begin
                if (q.size() == 0) chk({tg, " extra pulse"}, 64'd1, 64'd0);
                else chk({tg, " sb data"}, 64'(phy_data), 64'(q.pop_front()));
            end
            prev_clk = phy_clk;
            if (k == ka) ctrl_abort = 1'b1;
            if (k == ka + 1) ctrl_abort = 1'b0;
            if (disturb && k == 10) begin
                ctrl_go = 1'b1; ctrl_div = 4'd7; ctrl_ncols = 6'd0; ctrl_plane = 3'd3;
            end
            if (disturb && k == 11) ctrl_go = 1'b0;
        end
        if (abort_col < 0) chk($sformatf("p%0d n%0d d%0d sb left", p, n, d), 64'(q.size()), 64'd0);
    endtask

    initial begin
        bit seen;
        for (int c = 0; c < 64; c++) begin
            logic [63:0] t;
            t = {$urandom(), $urandom()};
            mem[c] = t[W-1:0];
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        // reset state held with no go
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk_idle($sformatf("reset k%0d", k));
            chk($sformatf("reset k%0d addr", k), 64'(ram_col_addr), 64'd0);
        end

        // plane 0 carries column parity on every lane
        for (int c = 0; c < 64; c++)
            for (int i = 0; i < NL; i++) mem[c][i*NP] = 1'(c % 2);
        run_line(0, 63, 0, -1, 1'b0);
        run_line(7, 3, 2, -1, 1'b0);
        run_line(5, 0, 0, -1, 1'b0);
        run_line(1, 5, 1, -1, 1'b1);
        run_line(2, 9, 1, 5, 1'b0);
        run_line(4, 2, 3, -1, 1'b0);

        // asynchronous reset while phy_clk is high
        @(negedge clk);
        ctrl_plane = 3'd6; ctrl_ncols = 6'd7; ctrl_div = 4'd3; ctrl_go = 1'b1;
        @(posedge clk);
        #1 ctrl_go = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = phy_clk;
        end
        chk("rst mid phy_clk high seen", 64'(seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_idle("rst async");
        chk("rst async addr", 64'(ram_col_addr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle($sformatf("rst hold k%0d", k));
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("post rst k%0d done", k), 64'(ctrl_done), 64'd0);
        end
        run_line(3, 4, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
